// File: rtl/scytale_decryption.sv
// Scytale decryption stage: buffers ciphertext until the start token, then
// streams the plaintext column-major over an N x M grid, one byte per cycle.
module scytale_decryption #(
  parameter int              D_WIDTH                = 8,
  parameter int              KEY_WIDTH              = 8,
  parameter int              MAX_NOKEYS             = 50,
  parameter logic [D_WIDTH-1:0] START_DECRYPTION_TOKEN = 8'hFA
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [D_WIDTH-1:0]   data_i,
  input  logic                 valid_i,
  input  logic [KEY_WIDTH-1:0] key_N,
  input  logic [KEY_WIDTH-1:0] key_M,
  output logic                 busy,
  output logic [D_WIDTH-1:0]   data_o,
  output logic                 valid_o
);

  localparam int CNT_W = $clog2(MAX_NOKEYS + 1);
  localparam int IDX_W = $clog2(MAX_NOKEYS);
  localparam int AW    = 2 * KEY_WIDTH;

  typedef enum logic [0:0] {IDLE, DECRYPT} state_t;

  state_t               state;
  logic [CNT_W-1:0]     count;
  logic [CNT_W-1:0]     len;
  logic [CNT_W-1:0]     out_cnt;
  logic [KEY_WIDTH-1:0] key_n;
  logic [KEY_WIDTH-1:0] key_m;
  logic [KEY_WIDTH-1:0] row;
  logic [KEY_WIDTH-1:0] col;
  logic [AW-1:0]        addr;
  logic [AW-1:0]        prod;
  logic [D_WIDTH-1:0]   mem [MAX_NOKEYS];
  logic [D_WIDTH-1:0]   rd_data;

  logic is_token;
  logic wr_en;

  assign is_token = (data_i == START_DECRYPTION_TOKEN);
  assign wr_en    = (state == IDLE) && valid_i && !is_token && (count < CNT_W'(MAX_NOKEYS));
  assign prod     = key_N * key_M;
  // Addresses past the buffer only arise on a key/length mismatch; read zero there.
  assign rd_data  = (addr < AW'(MAX_NOKEYS)) ? mem[addr[IDX_W-1:0]] : '0;

  // NOTE: the message buffer has no reset; its contents are only read after being
  // written, so clearing it would cost a wide reset tree for no functional gain.
  always_ff @(posedge clk) begin
    if (wr_en) mem[count[IDX_W-1:0]] <= data_i;
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      count   <= '0;
      len     <= '0;
      out_cnt <= '0;
      key_n   <= '0;
      key_m   <= '0;
      row     <= '0;
      col     <= '0;
      addr    <= '0;
      busy    <= 1'b0;
      valid_o <= 1'b0;
      data_o  <= '0;
    end else begin
      case (state)
        IDLE: begin
          valid_o <= 1'b0;
          data_o  <= '0;
          if (wr_en) begin
            count <= count + 1'b1;
          end else if (valid_i && is_token && count != '0) begin
            key_n   <= key_N;
            key_m   <= key_M;
            len     <= (prod > AW'(MAX_NOKEYS)) ? CNT_W'(MAX_NOKEYS) : prod[CNT_W-1:0];
            out_cnt <= '0;
            row     <= '0;
            col     <= '0;
            addr    <= '0;
            busy    <= 1'b1;
            state   <= DECRYPT;
          end
        end

        DECRYPT: begin
          if (out_cnt != len) begin
            valid_o <= 1'b1;
            data_o  <= rd_data;
            out_cnt <= out_cnt + 1'b1;
            // Row is the fast index; stepping by M walks down one column.
            if (row == key_n - 1'b1) begin
              row  <= '0;
              col  <= col + 1'b1;
              addr <= AW'(col) + AW'(1);
            end else begin
              row  <= row + 1'b1;
              addr <= addr + AW'(key_m);
            end
          end else begin
            valid_o <= 1'b0;
            data_o  <= '0;
            busy    <= 1'b0;
            count   <= '0;
            out_cnt <= '0;
            row     <= '0;
            col     <= '0;
            addr    <= '0;
            state   <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_scytale_decryption.sv
// Directed bench for scytale_decryption: stimulus pushes expected plaintext into a
// queue, an independent monitor pops and compares every valid output byte.
module tb_scytale_decryption;

  localparam logic [7:0] TOKEN = 8'hFA;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_i;
  logic       valid_i;
  logic [7:0] key_N;
  logic [7:0] key_M;
  logic       busy;
  logic [7:0] data_o;
  logic       valid_o;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  scytale_decryption dut (
    .clk     (clk),
    .rst     (rst),
    .data_i  (data_i),
    .valid_i (valid_i),
    .key_N   (key_N),
    .key_M   (key_M),
    .busy    (busy),
    .data_o  (data_o),
    .valid_o (valid_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: outputs change only on posedge, so the negedge is a stable sample point.
  always @(negedge clk) begin
    if (!rst) begin
      if (valid_o) begin
        if (exp_q.size() == 0) check("unexpected_output", {24'h0, data_o}, 32'hDEAD);
        else check("data_o", {24'h0, data_o}, {24'h0, exp_q.pop_front()});
      end else begin
        check("data_o_idle_zero", {24'h0, data_o}, 32'h0);
      end
    end
  end

  // All stimulus tasks start and end on a negedge.
  task automatic send_msg(input string s, input bit gapped);
    for (int i = 0; i < s.len(); i++) begin
      data_i = s[i]; valid_i = 1'b1;
      @(negedge clk);
      if (gapped) begin
        valid_i = 1'b0;
        @(negedge clk);
      end
    end
  endtask

  task automatic send_token();
    data_i = TOKEN; valid_i = 1'b1;
    @(negedge clk);
  endtask

  task automatic push_exp(input string s);
    for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
  endtask

  // Counts busy/valid cycles until busy drops; optionally drives junk while busy.
  task automatic drain(input int exp_len, input bit junk, input bit swap_keys);
    int bc = 0;
    int vc = 0;
    int t  = 0;
    data_i  = junk ? 8'h55 : 8'h00;
    valid_i = junk;
    if (swap_keys) begin
      key_N = 8'd1; key_M = 8'd1;
    end
    while (busy && t < 200) begin
      if (valid_o) vc++;
      bc++; t++;
      @(negedge clk);
    end
    valid_i = 1'b0;
    check("busy_timeout", (t < 200) ? 32'd1 : 32'd0, 32'd1);
    check("busy_cycles", bc, exp_len + 1);
    check("valid_cycles", vc, exp_len);
    check("idle_valid", {31'h0, valid_o}, 32'h0);
    check("idle_busy", {31'h0, busy}, 32'h0);
  endtask

  initial begin
    rst = 1'b1; data_i = '0; valid_i = 1'b0; key_N = 8'd2; key_M = 8'd3;
    @(negedge clk);
    check("reset_busy", {31'h0, busy}, 32'h0);
    check("reset_valid", {31'h0, valid_o}, 32'h0);
    check("reset_data", {24'h0, data_o}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // Basic 2x3 decrypt.
    send_msg("ACEBDF", 1'b0);
    push_exp("ABCDEF");
    send_token();
    drain(6, 1'b0, 1'b0);

    // Square key with gapped input.
    key_N = 8'd3; key_M = 8'd3;
    send_msg("ADGBEHCFI", 1'b1);
    push_exp("ABCDEFGHI");
    send_token();
    drain(9, 1'b0, 1'b0);

    // Junk while busy, then a second message starting the cycle busy falls.
    key_N = 8'd2; key_M = 8'd3;
    send_msg("ACEBDF", 1'b0);
    push_exp("ABCDEF");
    send_token();
    drain(6, 1'b1, 1'b0);
    send_msg("ACEBDF", 1'b0);
    push_exp("ABCDEF");
    send_token();
    drain(6, 1'b0, 1'b0);

    // Overflow: only the first 50 of 60 bytes are kept.
    key_N = 8'd5; key_M = 8'd10;
    for (int i = 0; i < 60; i++) begin
      data_i = 8'(i); valid_i = 1'b1;
      @(negedge clk);
    end
    // With N*M == 50 the scytale index (k%5)*10 + k/5 equals the stored byte value.
    for (int k = 0; k < 50; k++) exp_q.push_back(8'((k % 5) * 10 + k / 5));
    check("ovf_first3", {8'h0, exp_q[0], exp_q[1], exp_q[2]}, 32'h00000A14);
    send_token();
    drain(50, 1'b0, 1'b0);

    // Lone token in IDLE is ignored.
    send_token();
    valid_i = 1'b0;
    check("lone_token_busy", {31'h0, busy}, 32'h0);
    check("lone_token_valid", {31'h0, valid_o}, 32'h0);
    @(negedge clk);
    check("lone_token_busy2", {31'h0, busy}, 32'h0);

    // Async reset at the third output.
    key_N = 8'd2; key_M = 8'd3;
    send_msg("ACEBDF", 1'b0);
    push_exp("ABCDEF");
    send_token();
    valid_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_rst_valid", {31'h0, valid_o}, 32'h1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_valid", {31'h0, valid_o}, 32'h0);
    check("async_rst_busy", {31'h0, busy}, 32'h0);
    check("async_rst_data", {24'h0, data_o}, 32'h0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    send_msg("ACEBDF", 1'b0);
    push_exp("ABCDEF");
    send_token();
    drain(6, 1'b0, 1'b0);

    // Key changes after the token are ignored.
    key_N = 8'd2; key_M = 8'd3;
    send_msg("ACEBDF", 1'b0);
    push_exp("ABCDEF");
    send_token();
    drain(6, 1'b0, 1'b1);

    repeat (3) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
